// File: rtl/varredura_pkg.sv
// Shared types for the polynomial sweep sequencer: FSM states, widths and the
// (X, result, overflow) tuple carried by the output FIFO.
package varredura_pkg;

  localparam int W         = 16;
  localparam int OVF_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT,
    STORE,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] res;
    logic         ovf;
  } tupla_t;

endpackage

// File: rtl/varredura_polinomio_if.sv
// Evaluator launch/completion bus plus the valid/ready result stream.
// The sequencer takes the master side; evaluator and consumer sit on the slave side.
interface varredura_polinomio_if;
  import varredura_pkg::*;

  logic         ev_inicio;
  logic [W-1:0] ev_X;
  logic [W-1:0] ev_A;
  logic [W-1:0] ev_B;
  logic [W-1:0] ev_C;
  logic [W-1:0] ev_resultado;
  logic         ev_pronto;
  logic         ev_overflow;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_res;
  logic         out_ovf;

  modport master (
    output ev_inicio, ev_X, ev_A, ev_B, ev_C,
    input  ev_resultado, ev_pronto, ev_overflow,
    output out_valid, out_x, out_res, out_ovf,
    input  out_ready
  );

  modport slave (
    input  ev_inicio, ev_X, ev_A, ev_B, ev_C,
    output ev_resultado, ev_pronto, ev_overflow,
    input  out_valid, out_x, out_res, out_ovf,
    output out_ready
  );

endinterface

// File: rtl/fifo_tupla.sv
// DEPTH-entry tuple FIFO; the head is read straight from storage so it is a
// registered value. Push and pop in the same cycle are both honoured when full.
module fifo_tupla
  import varredura_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   ck,
  input  logic   rst,
  input  logic   push,
  input  tupla_t din,
  input  logic   ready,
  output tupla_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  tupla_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ready && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: storage is reset on purpose so the head outputs read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/varredura_polinomio.sv
// Sweep sequencer: launches one polynomial evaluation per X in [x_ini, x_fim]
// and queues each result. Define VARREDURA_TIMEOUT_EN to add a WAIT watchdog.
module varredura_polinomio
  import varredura_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef VARREDURA_TIMEOUT_EN
  , parameter int TMO = 64
`endif
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         x_ini,
  input  logic [W-1:0]         x_fim,
  input  logic [W-1:0]         passo,
  input  logic [W-1:0]         a_in,
  input  logic [W-1:0]         b_in,
  input  logic [W-1:0]         c_in,
  output logic                 busy,
  output logic                 done,
  output logic [OVF_CNT_W-1:0] ovf_count,
  varredura_polinomio_if.master bus
);

  state_t       state;
  logic [W-1:0] x_cur;
  logic [W-1:0] x_end;
  logic [W-1:0] step;
  logic [W-1:0] res_q;
  logic         ovf_q;
  logic [W:0]   nx;
  logic         fifo_full;
  logic         fifo_empty;
  tupla_t       din;
  tupla_t       head;

`ifdef VARREDURA_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] wd;
`endif

  // One extra bit so a sweep ending near the top of the range cannot wrap to 0.
  assign nx  = {1'b0, x_cur} + {1'b0, step};
  assign din = '{x: x_cur, res: res_q, ovf: ovf_q};

  fifo_tupla #(.DEPTH(DEPTH)) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (state == STORE),
    .din   (din),
    .ready (bus.out_ready),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_x     = head.x;
  assign bus.out_res   = head.res;
  assign bus.out_ovf   = head.ovf;

  // NOTE: every register here uses <= so all branches see pre-edge values.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x_cur     <= '0;
      x_end     <= '0;
      step      <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf_count <= '0;
      bus.ev_inicio <= 1'b0;
      bus.ev_X      <= '0;
      bus.ev_A      <= '0;
      bus.ev_B      <= '0;
      bus.ev_C      <= '0;
`ifdef VARREDURA_TIMEOUT_EN
      wd        <= '0;
`endif
    end else begin
      bus.ev_inicio <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_cur     <= x_ini;
          x_end     <= x_fim;
          step      <= (passo == '0) ? W'(1) : passo;
          bus.ev_A  <= a_in;
          bus.ev_B  <= b_in;
          bus.ev_C  <= c_in;
          ovf_count <= '0;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (x_end < x_cur) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          state <= FIRE;
        end
        // The slot checked here stays free until STORE: nothing else pushes.
        FIRE: if (!fifo_full) begin
          bus.ev_inicio <= 1'b1;
          bus.ev_X      <= x_cur;
`ifdef VARREDURA_TIMEOUT_EN
          wd            <= '0;
`endif
          state         <= WAIT;
        end
        WAIT: if (bus.ev_pronto) begin
          res_q <= bus.ev_resultado;
          ovf_q <= bus.ev_overflow;
          state <= STORE;
        end
`ifdef VARREDURA_TIMEOUT_EN
        else if (wd == TW'(TMO - 1)) begin
          res_q <= '0;
          ovf_q <= 1'b1;
          state <= STORE;
        end else begin
          wd <= wd + TW'(1);
        end
`endif
        STORE: begin
          if (ovf_q && (ovf_count != '1)) ovf_count <= ovf_count + OVF_CNT_W'(1);
          state <= NEXT;
        end
        NEXT: if (nx[W] || (nx[W-1:0] > x_end)) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          x_cur <= nx[W-1:0];
          state <= FIRE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_varredura_polinomio.sv
// Directed bench for varredura_polinomio with a behavioural evaluator
// (result = A*X^2 + B*X + C) and a collector for the output stream.
module tb_varredura_polinomio;
  import varredura_pkg::*;

  logic                 ck  = 1'b0;
  logic                 rst = 1'b0;
  logic                 start;
  logic [W-1:0]         x_ini, x_fim, passo, a_in, b_in, c_in;
  logic                 busy, done;
  logic [OVF_CNT_W-1:0] ovf_count;

  int checks = 0;
  int errors = 0;

  varredura_polinomio_if bus ();

  varredura_polinomio #(.DEPTH(4)) dut (
    .ck        (ck),
    .rst       (rst),
    .start     (start),
    .x_ini     (x_ini),
    .x_fim     (x_fim),
    .passo     (passo),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .ovf_count (ovf_count),
    .bus       (bus)
  );

  always #5 ck = ~ck;

  // Evaluator model: result appears ev_lat cycles after the launch pulse.
  int           ev_lat       = 2;
  int           ev_cnt       = 0;
  logic         force_ovf    = 1'b0;
  int           launch_count = 0;
  logic [W-1:0] last_x       = '0;
  logic [47:0]  p;

  function automatic logic [47:0] poly(input logic [15:0] a, b, c, x);
    return 48'(a) * 48'(x) * 48'(x) + 48'(b) * 48'(x) + 48'(c);
  endfunction

  assign p = poly(bus.ev_A, bus.ev_B, bus.ev_C, bus.ev_X);

  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      ev_cnt           <= 0;
      bus.ev_pronto    <= 1'b0;
      bus.ev_resultado <= '0;
      bus.ev_overflow  <= 1'b0;
    end else begin
      bus.ev_pronto <= 1'b0;
      if (bus.ev_inicio) begin
        ev_cnt       <= ev_lat;
        launch_count <= launch_count + 1;
        last_x       <= bus.ev_X;
      end else if (ev_cnt == 1) begin
        ev_cnt           <= 0;
        bus.ev_pronto    <= 1'b1;
        bus.ev_resultado <= p[15:0];
        bus.ev_overflow  <= force_ovf | (|p[47:16]);
      end else if (ev_cnt > 1) begin
        ev_cnt <= ev_cnt - 1;
      end
    end
  end

  logic [15:0] got_x[$];
  logic [15:0] got_res[$];
  logic        got_ovf[$];
  int          done_count = 0;

  always @(posedge ck) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      got_x.push_back(bus.out_x);
      got_res.push_back(bus.out_res);
      got_ovf.push_back(bus.out_ovf);
    end
    if (done) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] xi, xf, ps, a, b, c);
    @(posedge ck);
    #1;
    x_ini = xi; x_fim = xf; passo = ps;
    a_in  = a;  b_in  = b;  c_in  = c;
    start = 1'b1;
    @(posedge ck);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n0;
    n0 = done_count;
    for (int i = 0; i < budget && done_count == n0; i++) tick(1);
    check(tag, 32'(done_count - n0), 32'd1);
  endtask

  task automatic check_tuple(input string tag, input int idx,
                             input logic [15:0] ex, er, input logic eo);
    check({tag, "_x"},   32'(got_x[idx]),   32'(ex));
    check({tag, "_res"}, 32'(got_res[idx]), 32'(er));
    check({tag, "_ovf"}, 32'(got_ovf[idx]), 32'(eo));
  endtask

  logic [15:0] t1_res [4] = '{16'd3, 16'd6, 16'd11, 16'd18};
  int bx, bl, bd;

  initial begin
    start = 1'b0;
    x_ini = '0; x_fim = '0; passo = '0;
    a_in  = '0; b_in  = '0; c_in  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick(2);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_inicio",    32'(bus.ev_inicio), 32'd0);
    check("rst_ev_x",      32'(bus.ev_X),      32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_x",     32'(bus.out_x),     32'd0);
    check("rst_ovf_count", 32'(ovf_count),     32'd0);
    rst = 1'b1;
    tick(2);

    // 1: X = 0..3, A=1 B=2 C=3
    bus.out_ready = 1'b1;
    bx = got_x.size(); bl = launch_count; bd = done_count;
    do_start(16'd0, 16'd3, 16'd1, 16'd1, 16'd2, 16'd3);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(200, "t1_done_seen");
    tick(4);
    check("t1_launches", 32'(launch_count - bl), 32'd4);
    check("t1_count",    32'(got_x.size() - bx), 32'd4);
    for (int i = 0; i < 4; i++) check_tuple("t1", bx + i, 16'(i), t1_res[i], 1'b0);
    check("t1_done_once", 32'(done_count - bd), 32'd1);
    check("t1_ovf_count", 32'(ovf_count),       32'd0);
    check("t1_busy_low",  32'(busy),            32'd0);
    check("t1_empty",     32'(bus.out_valid),   32'd0);

    // 2: x_fim < x_ini, done two cycles after start
    bx = got_x.size(); bl = launch_count;
    do_start(16'd5, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1);
    check("t2_done_early", 32'(done), 32'd0);
    tick(1);
    check("t2_done_pulse", 32'(done), 32'd1);
    check("t2_busy_hold",  32'(busy), 32'd1);
    tick(1);
    check("t2_done_end",  32'(done), 32'd0);
    check("t2_busy_end",  32'(busy), 32'd0);
    tick(3);
    check("t2_launches",  32'(launch_count - bl), 32'd0);
    check("t2_count",     32'(got_x.size() - bx), 32'd0);
    check("t2_empty",     32'(bus.out_valid),     32'd0);

    // 3: passo 0 treated as 1, single point X=7 -> 49+7+1
    bx = got_x.size(); bl = launch_count;
    do_start(16'd7, 16'd7, 16'd0, 16'd1, 16'd1, 16'd1);
    wait_done(200, "t3_done_seen");
    tick(3);
    check("t3_launches", 32'(launch_count - bl), 32'd1);
    check("t3_ev_x",     32'(last_x),            32'd7);
    check("t3_count",    32'(got_x.size() - bx), 32'd1);
    check_tuple("t3", bx, 16'd7, 16'd57, 1'b0);

    // 4: top of range, no wrap to 0 (result = X)
    bx = got_x.size(); bl = launch_count;
    do_start(16'hFFF0, 16'hFFFF, 16'h0008, 16'd0, 16'd1, 16'd0);
    wait_done(200, "t4_done_seen");
    tick(3);
    check("t4_launches", 32'(launch_count - bl), 32'd2);
    check("t4_count",    32'(got_x.size() - bx), 32'd2);
    check_tuple("t4a", bx,     16'hFFF0, 16'hFFF0, 1'b0);
    check_tuple("t4b", bx + 1, 16'hFFF8, 16'hFFF8, 1'b0);

    // 5: backpressure, 6 points into a 4-deep FIFO, result = 2X+1
    bus.out_ready = 1'b0;
    bx = got_x.size(); bl = launch_count;
    do_start(16'd10, 16'd15, 16'd1, 16'd0, 16'd2, 16'd1);
    tick(80);
    check("t5_stall_launches", 32'(launch_count - bl), 32'd4);
    check("t5_stall_busy",     32'(busy),              32'd1);
    check("t5_head_valid",     32'(bus.out_valid),     32'd1);
    check("t5_head_x",         32'(bus.out_x),         32'd10);
    check("t5_head_res",       32'(bus.out_res),       32'd21);
    tick(20);
    check("t5_no_inicio", 32'(launch_count - bl), 32'd4);
    bus.out_ready = 1'b1;
    wait_done(300, "t5_done_seen");
    tick(3);
    check("t5_count", 32'(got_x.size() - bx), 32'd6);
    for (int i = 0; i < 6; i++)
      check_tuple("t5", bx + i, 16'(10 + i), 16'(21 + 2 * i), 1'b0);

    // 6: overflow at X=2 with A=7FFF -> 1FFFC truncated
    force_ovf = 1'b1;
    bx = got_x.size();
    do_start(16'd2, 16'd2, 16'd1, 16'h7FFF, 16'd0, 16'd0);
    wait_done(200, "t6_done_seen");
    tick(3);
    force_ovf = 1'b0;
    check("t6_count",     32'(got_x.size() - bx), 32'd1);
    check_tuple("t6", bx, 16'd2, 16'hFFFC, 1'b1);
    check("t6_ovf_count", 32'(ovf_count), 32'd1);

    // Reset while waiting on the second point, one tuple still queued
    bus.out_ready = 1'b0;
    ev_lat = 20;
    bl = launch_count;
    do_start(16'd0, 16'd3, 16'd1, 16'd1, 16'd1, 16'd1);
    for (int i = 0; i < 200 && (launch_count - bl) < 2; i++) tick(1);
    check("rw_second_launch", 32'(launch_count - bl), 32'd2);
    tick(3);
    check("rw_queued", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_busy",      32'(busy),          32'd0);
    check("rw_done",      32'(done),          32'd0);
    check("rw_inicio",    32'(bus.ev_inicio), 32'd0);
    check("rw_ev_x",      32'(bus.ev_X),      32'd0);
    check("rw_ev_a",      32'(bus.ev_A),      32'd0);
    check("rw_out_valid", 32'(bus.out_valid), 32'd0);
    check("rw_out_x",     32'(bus.out_x),     32'd0);
    check("rw_out_res",   32'(bus.out_res),   32'd0);
    check("rw_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("rw_ovf_count", 32'(ovf_count),     32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
